// File: rtl/int_ctrl_pkg.sv
// Shared constants and types for the int_ctrl interrupt controller.
package int_ctrl_pkg;

  localparam int NUM_SRC_DEF = 6;

  localparam logic [3:0] INT_MASK = 4'h0;
  localparam logic [3:0] INT_MODE = 4'h4;
  localparam logic [3:0] INT_PEND = 4'h8;
  localparam logic [3:0] INT_STAT = 4'hC;

  localparam int CLAIM_BIT = 31;
  localparam int ID_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } int_state_e;

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority winner select (index 0 highest), gated by the in-service vector.
// INT_CTRL_NEST_EN: strictly higher-priority sources may preempt; otherwise any in-service source blocks all.
module int_prio_enc import int_ctrl_pkg::*; #(
  parameter int NUM_SRC = NUM_SRC_DEF
) (
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [NUM_SRC-1:0] i_insv,
  output logic               o_valid,
  output logic [ID_W-1:0]    o_id
);

`ifdef INT_CTRL_NEST_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  logic w_blocked;

  // Walking from index 0, the first in-service bit blocks itself and everything below it.
  always_comb begin
    o_valid   = 1'b0;
    o_id      = '0;
    w_blocked = !NEST && (|i_insv);
    for (int i = 0; i < NUM_SRC; i++) begin
      if (i_insv[i]) w_blocked = 1'b1;
      if (i_req[i] && !w_blocked && !o_valid) begin
        o_valid = 1'b1;
        o_id    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Programmable interrupt controller: edge/level capture, mask, claim/EOI register file, registered HWInt_O.
// Nesting is enabled by defining INT_CTRL_NEST_EN (handled inside int_prio_enc).
module int_ctrl import int_ctrl_pkg::*; #(
  parameter int NUM_SRC = NUM_SRC_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         ADD_I,
  input  logic               WE_I,
  input  logic [31:0]        DAT_I,
  output logic [31:0]        DAT_O,
  input  logic [NUM_SRC-1:0] IRQ_I,
  output logic [NUM_SRC-1:0] HWInt_O,
  output int_state_e         o_dbg_state
);

  logic [NUM_SRC-1:0] r_mask, r_mode, r_edge_pend, r_insv, r_irq_q, r_hwint;
  int_state_e         r_state;

  logic [NUM_SRC-1:0] w_rise, w_pend_eff, w_cand_oh;
  logic [NUM_SRC-1:0] w_claim_vec, w_w1c_vec, w_eoi_vec;
  logic               w_valid, w_wr_pend, w_claim, w_eoi, w_unused_dat;
  logic [ID_W-1:0]    w_id;

  assign w_rise     = IRQ_I & ~r_irq_q;
  assign w_pend_eff = ((r_mode & r_edge_pend) | (~r_mode & IRQ_I)) & r_mask;

  int_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio (
    .i_req   (w_pend_eff),
    .i_insv  (r_insv),
    .o_valid (w_valid),
    .o_id    (w_id)
  );

  assign w_cand_oh = NUM_SRC'(1) << w_id;

  // A PEND write with bit 31 set is a claim only; otherwise it is write-1-to-clear.
  assign w_wr_pend   = WE_I && (ADD_I == INT_PEND);
  assign w_claim     = w_wr_pend && DAT_I[CLAIM_BIT] && w_valid;
  assign w_claim_vec = w_claim ? w_cand_oh : '0;
  assign w_w1c_vec   = (w_wr_pend && !DAT_I[CLAIM_BIT]) ? DAT_I[NUM_SRC-1:0] : '0;

  assign w_eoi     = WE_I && (ADD_I == INT_STAT) && (int'(DAT_I[ID_W-1:0]) < NUM_SRC);
  assign w_eoi_vec = w_eoi ? (NUM_SRC'(1) << DAT_I[ID_W-1:0]) : '0;

  assign w_unused_dat = ^DAT_I[CLAIM_BIT-1:NUM_SRC];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask      <= '0;
      r_mode      <= '0;
      r_edge_pend <= '0;
      r_insv      <= '0;
      r_irq_q     <= '0;
    end else begin
      r_irq_q     <= IRQ_I;
      // A new rising edge beats a same-cycle clear.
      r_edge_pend <= (r_edge_pend & ~(w_w1c_vec | w_claim_vec)) | w_rise;
      r_insv      <= (r_insv & ~w_eoi_vec) | w_claim_vec;
      if (WE_I && (ADD_I == INT_MASK)) r_mask <= DAT_I[NUM_SRC-1:0];
      if (WE_I && (ADD_I == INT_MODE)) r_mode <= DAT_I[NUM_SRC-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_hwint <= '0;
    end else if (w_valid) begin
      r_state <= ST_REQ;
      r_hwint <= w_cand_oh;
    end else if (|r_insv) begin
      r_state <= ST_SERVICE;
      r_hwint <= '0;
    end else begin
      r_state <= ST_IDLE;
      r_hwint <= '0;
    end
  end

  assign HWInt_O     = r_hwint;
  assign o_dbg_state = r_state;

  always_comb begin
    DAT_O = '0;
    case (ADD_I)
      INT_MASK: DAT_O[NUM_SRC-1:0] = r_mask;
      INT_MODE: DAT_O[NUM_SRC-1:0] = r_mode;
      INT_PEND: DAT_O[NUM_SRC-1:0] = w_pend_eff;
      INT_STAT: begin
        DAT_O[31]          = w_valid;
        DAT_O[5 +: NUM_SRC] = r_insv;
        DAT_O[ID_W-1:0]    = w_id;
      end
      default: DAT_O = '0;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Testbench for int_ctrl: directed scenarios then random traffic, checked by a scoreboard
// fed from a behavioural model of the controller's rules.
module tb_int_ctrl;
  import int_ctrl_pkg::*;

  localparam int N  = NUM_SRC_DEF;
  localparam int EW = 1 + 32 + N;
`ifdef INT_CTRL_NEST_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   add_i;
  logic         we_i;
  logic [31:0]  dat_i, dat_o;
  logic [N-1:0] irq_i, hwint_o;
  int_state_e   dbg_state;

  always #5 clk = ~clk;

  int_ctrl #(.NUM_SRC(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .ADD_I       (add_i),
    .WE_I        (we_i),
    .DAT_I       (dat_i),
    .DAT_O       (dat_o),
    .IRQ_I       (irq_i),
    .HWInt_O     (hwint_o),
    .o_dbg_state (dbg_state)
  );

  // Scoreboard: {check_en, expected DAT_O, expected HWInt_O} per cycle.
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state.
  bit [N-1:0]   m_mask, m_mode, m_epend, m_insv, m_irq_q, m_hw;
  bit           m_known = 1'b0;
  logic [N-1:0] irq_lvl = '0;

  localparam logic [31:0] CLAIM = 32'h8000_0000;

  function automatic void model_eval(input bit [N-1:0] irq, output bit [N-1:0] pend,
                                     output bit v, output int id);
    int top_insv;
    int limit;
    top_insv = N;
    for (int i = N - 1; i >= 0; i--) if (m_insv[i]) top_insv = i;
    for (int i = 0; i < N; i++) pend[i] = m_mask[i] && (m_mode[i] ? m_epend[i] : irq[i]);
    if (NEST) limit = top_insv;
    else      limit = (m_insv == 0) ? N : 0;
    v  = 1'b0;
    id = 0;
    for (int i = 0; i < limit; i++) begin
      if (pend[i] && !v) begin
        v  = 1'b1;
        id = i;
      end
    end
  endfunction

  task automatic step(input bit rst, input bit we, input logic [3:0] addr, input logic [31:0] data);
    bit [N-1:0] pend, rise, clr;
    bit         v;
    int         id;
    bit [31:0]  exp_dat;
    reset = rst;
    we_i  = we;
    add_i = addr;
    dat_i = data;
    irq_i = irq_lvl;
    model_eval(irq_lvl, pend, v, id);
    exp_dat = '0;
    case (addr)
      INT_MASK: exp_dat[N-1:0] = m_mask;
      INT_MODE: exp_dat[N-1:0] = m_mode;
      INT_PEND: exp_dat[N-1:0] = pend;
      INT_STAT: exp_dat = {v, 20'b0, m_insv, 2'b0, 3'(id)};
      default:  exp_dat = '0;
    endcase
    exp_q.push_back({m_known, exp_dat, m_hw});
    @(posedge clk);
    if (rst) begin
      m_mask = '0; m_mode = '0; m_epend = '0; m_insv = '0; m_irq_q = '0; m_hw = '0;
      m_known = 1'b1;
    end else begin
      rise = irq_lvl & ~m_irq_q;
      clr  = (we && addr == INT_PEND && !data[31]) ? data[N-1:0] : '0;
      m_hw = '0;
      if (v) m_hw[id] = 1'b1;
      if (we && addr == INT_PEND && data[31] && v) begin
        clr[id]    = 1'b1;
        m_insv[id] = 1'b1;
      end
      if (we && addr == INT_STAT && int'(data[2:0]) < N) m_insv[data[2:0]] = 1'b0;
      m_epend = (m_epend & ~clr) | rise;
      if (we && addr == INT_MASK) m_mask = data[N-1:0];
      if (we && addr == INT_MODE) m_mode = data[N-1:0];
      m_irq_q = irq_lvl;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, INT_STAT, '0);
  endtask

  task automatic rd(input logic [3:0] addr);
    step(1'b0, 1'b0, addr, '0);
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] data);
    step(1'b0, 1'b1, addr, data);
  endtask

  // Monitor: compares HWInt_O and DAT_O mid-cycle against the popped expectation.
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e[EW-1]) begin
          n_checks++;
          if (hwint_o !== e[N-1:0]) begin
            n_fail++;
            $display("FAIL hwint t=%0t got %b exp %b", $time, hwint_o, e[N-1:0]);
          end
          n_checks++;
          if (dat_o !== e[N +: 32]) begin
            n_fail++;
            $display("FAIL dat_o t=%0t addr=%h got %h exp %h", $time, add_i, dat_o, e[N +: 32]);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; we_i = 1'b0; add_i = '0; dat_i = '0; irq_i = '0;
    @(posedge clk);
    #1;
    repeat (3) step(1'b1, 1'b0, INT_MASK, '0);
    rd(INT_MASK); rd(INT_MODE); rd(INT_PEND); rd(INT_STAT);

    // Single edge source: pulse, claim, EOI.
    wr(INT_MASK, 32'h3); wr(INT_MODE, 32'h1); idle(3);
    irq_lvl = 6'b000001; idle(1); irq_lvl = '0; idle(2);
    rd(INT_STAT);
    wr(INT_PEND, CLAIM); idle(2); rd(INT_STAT);
    wr(INT_STAT, 32'h0); rd(INT_STAT);

    // Level source 1 in service, then edge on source 0.
    irq_lvl = 6'b000010; idle(2);
    wr(INT_PEND, CLAIM); idle(2);
    irq_lvl = 6'b000011; idle(4); rd(INT_STAT); rd(INT_PEND);
    wr(INT_STAT, 32'h7); wr(INT_STAT, 32'h4); idle(1);
    wr(INT_STAT, 32'h1); idle(3);
    wr(INT_PEND, CLAIM); idle(2); wr(INT_STAT, 32'h0); idle(2);

    // Clear racing a new edge.
    irq_lvl = '0; wr(INT_PEND, 32'h3f); idle(1);
    irq_lvl = 6'b000001; wr(INT_PEND, 32'h1); rd(INT_PEND); idle(2);

    // Masked level source.
    wr(INT_MASK, 32'h0); wr(INT_MODE, 32'h0); irq_lvl = 6'b000100; idle(3); rd(INT_PEND);

    // Reset in the middle of service.
    wr(INT_MASK, 32'h3f); idle(2); wr(INT_PEND, CLAIM); idle(1);
    irq_lvl = 6'b000101; idle(2);
    step(1'b1, 1'b0, INT_STAT, '0);
    rd(INT_MASK); rd(INT_MODE); rd(INT_PEND); rd(INT_STAT);
    irq_lvl = '0; idle(2); irq_lvl = 6'b111111; idle(3); rd(INT_PEND);
    wr(INT_MASK, 32'h3f); idle(2); rd(INT_STAT);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(0, 7) == 0) irq_lvl[b] = ~irq_lvl[b];
      if ($urandom_range(0, 299) == 0) begin
        step(1'b1, 1'b0, INT_MASK, '0);
      end else begin
        case ($urandom_range(0, 11))
          0:       wr(INT_MASK, {26'b0, 6'($urandom | $urandom)});
          1:       wr(INT_MODE, {26'b0, 6'($urandom)});
          2:       wr(INT_PEND, {26'b0, 6'($urandom)});
          3, 4:    wr(INT_PEND, CLAIM);
          5:       wr(INT_STAT, 32'($urandom_range(0, 7)));
          6:       step(1'b0, 1'($urandom), 4'($urandom), {1'b0, 31'($urandom)});
          7:       rd(INT_MASK);
          8:       rd(INT_PEND);
          default: rd(INT_STAT);
        endcase
      end
    end

    idle(2);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Programmable interrupt controller between the peripheral IRQ lines (Timer0, Timer1, future devices) and the CPU `HWInt[7:2]` inputs. It latches or passes through each source, applies a mask, and selects one fixed-priority winner. It tracks claim and end-of-interrupt (EOI) through a small register file mapped behind the bridge as another device. The CPU sees at most one `HWInt` bit at a time.

## Interface
Parameters:
- `NUM_SRC`, 6: number of IRQ sources. Index 0 has the highest priority. Source i drives `HWInt_O[i]`.

Ports:
- `clk` in 1: single clock; everything updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `ADD_I` in 4: word offset from the bridge (`DEV_Addr[3:0]`).
- `WE_I` in 1: write strobe for one cycle, from the bridge.
- `DAT_I` in 32: write data.
- `DAT_O` out 32: read data. Combinational from `ADD_I` and the current registers.
- `IRQ_I` in NUM_SRC: raw device requests (timer `IRQ_O`s).
- `HWInt_O` out NUM_SRC: registered request to the CPU. One-hot or zero.

## Operation
- Registers. Bits not listed read 0 and ignore writes.
  - 0x0 MASK[5:0], RW: 1 = source enabled. Resets to 0.
  - 0x4 MODE[5:0], RW: 1 = edge, 0 = level. Resets to 0.
  - 0x8 PEND[5:0]:
    - Read returns the effective pending vector.
    - Writing 1 to a bit clears that edge-pending bit. Level bits are unaffected.
    - Write with `WE_I`, any data, while `DAT_I[31]=1` performs CLAIM (see below).
  - 0xC STAT:
    - Read returns `{valid[31], 20'b0, INSV[10:5], 2'b0, cand_id[2:0]}`.
    - Write performs EOI for id `DAT_I[2:0]`.
- Edge detect: `irq_q` holds the `IRQ_I` value from the previous cycle. A rising edge is `IRQ_I & ~irq_q`.
- Edge-pending bit: set on a rising edge, cleared by W1C or CLAIM. Set wins over clear in the same cycle.
- Effective pending: `pend_eff = (MODE ? edge_pend : IRQ_I) & MASK`.
- Candidate:
  - The lowest index in `pend_eff` whose priority is strictly higher than every in-service source (INSV bit set).
  - `valid` is 1 when such a source exists, otherwise 0; `cand_id` is that source's index, 0 when none.
- State per controller:
  - IDLE: `valid=0`, `HWInt_O=0`.
  - REQ: `valid=1`; `HWInt_O` is one-hot at `cand_id`.
  - SERVICE: INSV is non-zero and `valid=0`.
- CLAIM:
  - If `valid`, set `INSV[cand_id]` and clear `edge_pend[cand_id]`.
  - If not `valid`, no effect.
- EOI clears `INSV[id]`.
  - An EOI for an id that is not in service, or ≥ NUM_SRC, is ignored.
- Simultaneous CLAIM and rising edge on the same source: the edge wins. The pending bit stays set and INSV is set.
- Changing MASK does not alter INSV. A masked source already in service stays in service until EOI.

## Timing
- `HWInt_O` is registered: `HWInt_O(n+1) = onehot(cand_id(n)) & valid(n)`.
- Edge-source latency: rising edge seen at cycle n, `edge_pend` set at n+1, `HWInt_O` at n+2.
- Level-source latency: `IRQ_I` high at cycle n, `HWInt_O` at n+1.
- After a CLAIM write at cycle n:
  - INSV is updated at n+1.
  - `HWInt_O` drops, or moves to the next eligible source, at n+2.
- Reset asserted on any cycle, including mid-service:
  - Next cycle: MASK, MODE, `edge_pend`, INSV, `irq_q` and `HWInt_O` are all 0.
  - `DAT_O` reads 0 at every offset.

## Configuration
- `INT_CTRL_NEST_EN` defined:
  - INSV is a vector, so several sources can be in service at once.
  - A strictly higher-priority source preempts the current one (nested interrupts).
- Not defined:
  - At most one source is in service.
  - `valid` is forced to 0 whenever INSV ≠ 0.
  - CLAIM while INSV ≠ 0 is ignored.
  - INSV still reads as 6 bits.

## Structure
- Shared package `int_ctrl_pkg`:
  - `NUM_SRC` default.
  - Register offsets `INT_MASK=4'h0`, `INT_MODE=4'h4`, `INT_PEND=4'h8`, `INT_STAT=4'hC`.
  - Claim bit index 31 and the id width of 3.
- Sub-module `int_prio_enc`:
  - Combinational, fixed-priority, lowest index first.
  - Inputs: request vector and in-service vector.
  - Outputs: `valid` and `id`.
- The top of `int_ctrl` holds the registers, edge detect and bus decode.

## Test plan
- Unmask one source: write MASK=6'b000011 and MODE=6'b000001, pulse `IRQ_I[0]` for 1 cycle at cycle 10.
  - `HWInt_O=6'b000001` at cycle 12.
  - STAT reads `32'h8000_0000`.
- Claim and EOI: CLAIM at cycle 14.
  - `HWInt_O=0` at cycle 16.
  - STAT `INSV[5]=1`.
  - Write STAT=0 → INSV=0 next cycle.
- Priority under nesting: hold level `IRQ_I[1]`, claim it, then raise edge `IRQ_I[0]`.
  - `INT_CTRL_NEST_EN` defined: `HWInt_O=6'b000001`.
  - Not defined: `HWInt_O=0` until EOI(1).
- Pending clear race: W1C PEND=1 in the same cycle as a rising edge on `IRQ_I[0]` → `PEND[0]` stays 1.
- Mask a level source: with MASK=0, hold `IRQ_I[2]` high → `HWInt_O` stays 0 and PEND reads 0.
- Reset mid-service: reset with INSV≠0 and `HWInt_O≠0`.
  - Next cycle: all registers 0 and `HWInt_O=0`.
  - Rising edges are ignored until the sources are unmasked again.
